// File: rtl/w480_to_byte.sv
// w480_to_byte: serializes one DATA_WIDTH-bit word (plus control word) into an
// MSB-first byte stream with valid/ready handshake and a trailing newpkt pulse.
// Optional feature macro: CTRL_PREPEND_EN (emit the 4 control bytes before data).
module w480_to_byte #(
   parameter int unsigned DATA_WIDTH = 480,
   parameter int unsigned CTRL_WIDTH = 32,
   parameter int unsigned IFG_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_wr,
   input  logic [CTRL_WIDTH-1:0] in_ctl,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [5:0]            in_len,
   output logic                  in_rdy,
   output logic                  in_drop,
   input  logic                  out_ready,
   output logic [7:0]            data_out,
   output logic                  datavalid,
   output logic                  newpkt,
   output logic [CTRL_WIDTH-1:0] out_ctl
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned CBYTES = CTRL_WIDTH / 8;
   localparam int unsigned LEN_W  = 6;
   localparam int unsigned GAP_W  = 4;
   localparam logic [LEN_W-1:0] LAST_MAX  = LEN_W'(NBYTES - 1);
   localparam logic [LEN_W-1:0] CTRL_LAST = LEN_W'(CBYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
`ifdef CTRL_PREPEND_EN
      S_CTRL = 3'd1,
`endif
      S_DATA = 3'd2,
      S_EOP  = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t               state, state_nx;
   logic [LEN_W-1:0]     idx, idx_nx;
   logic [LEN_W-1:0]     last_r;
   logic [LEN_W-1:0]     in_last_c;
   logic [DATA_WIDTH-1:0] data_r;
   logic [GAP_W-1:0]     gap_cnt, gap_nx;
   logic [7:0]           data_nx;
   logic                 dv_nx, newpkt_nx, rdy_nx, drop_nx, accept_c, xfer_c;

   // Byte k of a data word, MSB-first
   function automatic logic [7:0] data_byte(input logic [DATA_WIDTH-1:0] w,
                                            input logic [LEN_W-1:0] k);
      data_byte = w[(NBYTES - 1 - int'(k)) * 8 +: 8];
   endfunction

   // Byte k of a control word, MSB-first
   function automatic logic [7:0] ctl_byte(input logic [CTRL_WIDTH-1:0] w,
                                           input logic [LEN_W-1:0] k);
      ctl_byte = w[(CBYTES - 1 - int'(k)) * 8 +: 8];
   endfunction

   // Clamp requested length to the word size; 0 or oversize means full word
   assign in_last_c = (in_len == '0 || in_len > LEN_W'(NBYTES)) ? LAST_MAX
                                                                : in_len - LEN_W'(1);

   assign xfer_c = datavalid & out_ready;

   // Next-state and next-output decode
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      gap_nx    = gap_cnt;
      data_nx   = data_out;
      dv_nx     = datavalid;
      newpkt_nx = 1'b0;
      accept_c  = 1'b0;
      case (state)
         S_IDLE: begin
            dv_nx   = 1'b0;
            data_nx = 8'h00;
            if (in_wr) begin
               accept_c = 1'b1;
               idx_nx   = '0;
               dv_nx    = 1'b1;
`ifdef CTRL_PREPEND_EN
               state_nx = S_CTRL;
               data_nx  = ctl_byte(in_ctl, '0);
`else
               state_nx = S_DATA;
               data_nx  = data_byte(in_data, '0);
`endif
            end
         end
`ifdef CTRL_PREPEND_EN
         S_CTRL: begin
            if (xfer_c) begin
               if (idx == CTRL_LAST) begin
                  state_nx = S_DATA;
                  idx_nx   = '0;
                  data_nx  = data_byte(data_r, '0);
               end else begin
                  idx_nx  = idx + LEN_W'(1);
                  data_nx = ctl_byte(out_ctl, idx + LEN_W'(1));
               end
            end
         end
`endif
         S_DATA: begin
            if (xfer_c) begin
               if (idx == last_r) begin
                  state_nx  = S_EOP;
                  dv_nx     = 1'b0;
                  data_nx   = 8'h00;
                  newpkt_nx = 1'b1;
               end else begin
                  idx_nx  = idx + LEN_W'(1);
                  data_nx = data_byte(data_r, idx + LEN_W'(1));
               end
            end
         end
         S_EOP: begin
            gap_nx   = '0;
            state_nx = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
            else                     gap_nx   = gap_cnt + GAP_W'(1);
         end
         default: state_nx = S_IDLE;
      endcase
      rdy_nx  = (state_nx == S_IDLE);
      drop_nx = in_wr & (state != S_IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         gap_cnt   <= '0;
         last_r    <= '0;
         data_r    <= '0;
         out_ctl   <= '0;
         data_out  <= 8'h00;
         datavalid <= 1'b0;
         newpkt    <= 1'b0;
         in_rdy    <= 1'b1;
         in_drop   <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         gap_cnt   <= gap_nx;
         data_out  <= data_nx;
         datavalid <= dv_nx;
         newpkt    <= newpkt_nx;
         in_rdy    <= rdy_nx;
         in_drop   <= drop_nx;
         if (accept_c) begin
            last_r  <= in_last_c;
            data_r  <= in_data;
            out_ctl <= in_ctl;
         end
      end
   end

endmodule
